// File: rtl/la_capture_core.sv
// Trigger-and-capture engine: synchronizes probes, records a circular pre/post-trigger window, streams it oldest-first.
// Latency: probe->RAM 3 clk; READ entry -> first rd_valid 2 clk, then 1 word/clk with rd_ready held high.
// Backpressure: rd_ready low stalls the stream; RAM output plus a skid register keep data stable without loss.
module la_capture_core #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          btnCpuReset,
    input  logic [DW-1:0] probe_in,
    input  logic          sample_en,
    input  logic [DW-1:0] trig_mask,
    input  logic [DW-1:0] trig_value,
    input  logic [DW-1:0] trig_edge,
    input  logic [AW-1:0] pretrig,
    input  logic          arm,
    input  logic          abort,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_last,
    input  logic          rd_ready,
    output logic [2:0]    state,
    output logic          triggered,
    output logic          done
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
    localparam logic [AW:0]   N_WORDS  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LAST_IDX = (AW + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t st;

    // probe synchronizer and previous-sample history
    logic [DW-1:0] s_meta;
    logic [DW-1:0] s;
    logic [DW-1:0] s_prev;

    // trigger configuration captured at arm
    logic [DW-1:0] mask_q;
    logic [DW-1:0] value_q;
    logic [DW-1:0] edge_q;
    logic [AW-1:0] pretrig_q;

    // capture-side addressing and counters
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] fill_cnt;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] trig_addr;

    // read-side addressing and pipeline
    logic [AW-1:0] rd_addr;
    logic [AW:0]   iss_cnt;
    logic          rq_vld;
    logic          rq_last;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] skid_dat;
    logic          skid_vld;
    logic          skid_last;

    logic [DW-1:0] mem [DEPTH];

    logic          hit;
    logic          wr_en;
    logic          pop;
    logic [1:0]    occ;
    logic [1:0]    occ_after;
    logic          issue;
    logic [AW-1:0] post_load;
    logic [AW-1:0] rd_start;

    assign state = st;

    // Pattern on masked bits must match; if any edge bits are set, at least one of them must have toggled.
    assign hit = (((s ^ value_q) & mask_q) == '0) &&
                 ((edge_q == '0) || (((s ^ s_prev) & edge_q) != '0));

    assign wr_en = sample_en && !abort &&
                   ((st == ST_FILL) || (st == ST_ARMED) || (st == ST_POST));

    assign post_load = ADDR_MAX - pretrig_q;

    // When leaving ARMED directly, trig_addr is being written this same cycle, so use wr_addr.
    assign rd_start = ((st == ST_ARMED) ? wr_addr : trig_addr) - pretrig_q;

    // Words held or in flight: output register, skid register, and the RAM read in progress.
    assign pop       = rd_valid && rd_ready;
    assign occ       = 2'(rd_valid) + 2'(skid_vld) + 2'(rq_vld);
    assign occ_after = occ - 2'(pop);
    assign issue     = (st == ST_READ) && !abort && (iss_cnt != N_WORDS) && (occ_after < 2'd2);

    // Two-flop synchronizer on the asynchronous probe lines; s_prev tracks s across sample strobes.
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            s_meta <= '0;
            s      <= '0;
            s_prev <= '0;
        end else begin
            s_meta <= probe_in;
            s      <= s_meta;
            if (sample_en) begin
                s_prev <= s;
            end
        end
    end

    // Sample RAM: one write port for capture, one synchronous read port for streaming.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= s;
        end
        if (issue) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Capture/readout sequencer with sticky status flags.
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            st        <= ST_IDLE;
            mask_q    <= '0;
            value_q   <= '0;
            edge_q    <= '0;
            pretrig_q <= '0;
            wr_addr   <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            trig_addr <= '0;
            rd_addr   <= '0;
            iss_cnt   <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            st <= ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (arm) begin
                        wr_addr   <= '0;
                        fill_cnt  <= '0;
                        post_cnt  <= '0;
                        iss_cnt   <= '0;
                        triggered <= 1'b0;
                        done      <= 1'b0;
                        mask_q    <= trig_mask;
                        value_q   <= trig_value;
                        edge_q    <= trig_edge;
                        pretrig_q <= pretrig;
                        st        <= (pretrig == '0) ? ST_ARMED : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (sample_en) begin
                        wr_addr  <= wr_addr + ADDR_ONE;
                        fill_cnt <= fill_cnt + ADDR_ONE;
                        if ((fill_cnt + ADDR_ONE) == pretrig_q) begin
                            st <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (sample_en) begin
                        wr_addr <= wr_addr + ADDR_ONE;
                        if (hit) begin
                            trig_addr <= wr_addr;
                            triggered <= 1'b1;
                            post_cnt  <= post_load;
                            if (post_load == '0) begin
                                st      <= ST_READ;
                                rd_addr <= rd_start;
                                iss_cnt <= '0;
                            end else begin
                                st <= ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        wr_addr  <= wr_addr + ADDR_ONE;
                        post_cnt <= post_cnt - ADDR_ONE;
                        if (post_cnt == ADDR_ONE) begin
                            st      <= ST_READ;
                            rd_addr <= rd_start;
                            iss_cnt <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_addr <= rd_addr + ADDR_ONE;
                        iss_cnt <= iss_cnt + 1'b1;
                    end
                    if (pop && rd_last) begin
                        done <= 1'b1;
                        st   <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // Output stage: RAM word lands in the output register, or in the skid register while stalled.
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rq_vld    <= 1'b0;
            rq_last   <= 1'b0;
            skid_dat  <= '0;
            skid_vld  <= 1'b0;
            skid_last <= 1'b0;
        end else if (abort) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rq_vld   <= 1'b0;
            rq_last  <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            rq_vld  <= issue;
            rq_last <= issue && (iss_cnt == LAST_IDX);
            if (!rd_valid || pop) begin
                if (skid_vld) begin
                    rd_data   <= skid_dat;
                    rd_last   <= skid_last;
                    rd_valid  <= 1'b1;
                    skid_vld  <= rq_vld;
                    skid_dat  <= ram_q;
                    skid_last <= rq_last;
                end else if (rq_vld) begin
                    rd_data  <= ram_q;
                    rd_last  <= rq_last;
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end
            end else if (rq_vld) begin
                skid_dat  <= ram_q;
                skid_last <= rq_last;
                skid_vld  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_la_capture_core.sv
// Scoreboard bench for la_capture_core with a 16-deep sample RAM.
// Each capture's expected words are queued at arm and popped on every accepted transfer.
// Stall stability, last-flag placement, abort and async reset are checked along the way.
module tb_la_capture_core;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          btnCpuReset;
    logic [DW-1:0] probe_in;
    logic          sample_en;
    logic [DW-1:0] trig_mask;
    logic [DW-1:0] trig_value;
    logic [DW-1:0] trig_edge;
    logic [AW-1:0] pretrig;
    logic          arm;
    logic          abort;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          rd_ready;
    logic [2:0]    state;
    logic          triggered;
    logic          done;

    always #5 clk = ~clk;

    la_capture_core #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .btnCpuReset (btnCpuReset),
        .probe_in    (probe_in),
        .sample_en   (sample_en),
        .trig_mask   (trig_mask),
        .trig_value  (trig_value),
        .trig_edge   (trig_edge),
        .pretrig     (pretrig),
        .arm         (arm),
        .abort       (abort),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_last     (rd_last),
        .rd_ready    (rd_ready),
        .state       (state),
        .triggered   (triggered),
        .done        (done)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    int            nwords;
    bit            saw_last;
    bit            seen_valid;
    bit            stalled_prev;
    logic [DW-1:0] held_data;
    logic          held_last;

    bit cnt_mode;
    bit slow_mode;
    bit edge_mode;
    bit rand_ready;
    int ph;
    int k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        logic [DW-1:0] e;
        if (rd_valid) seen_valid = 1'b1;
        if (stalled_prev) begin
            check("stall_valid", 32'(rd_valid), 32'd1);
            check("stall_data", 32'(rd_data), 32'(held_data));
            check("stall_last", 32'(rd_last), 32'(held_last));
        end
        if (rd_valid && rd_ready) begin
            nwords++;
            if (exp_q.size() == 0) begin
                check("extra_word", 32'(nwords), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data", 32'(rd_data), 32'(e));
            end
            check("last_flag", 32'(rd_last), 32'(nwords == 16));
            if (rd_last) saw_last = 1'b1;
        end
        stalled_prev = rd_valid && !rd_ready;
        held_data    = rd_data;
        held_last    = rd_last;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 3;
        sample_en = slow_mode ? (ph == 0) : 1'b1;
        if (cnt_mode && (!slow_mode || ph == 0)) probe_in = probe_in + 16'd1;
        if (edge_mode) begin
            k++;
            probe_in = DW'((k << 1) | ((k >= 20) ? 1 : 0));
        end
        if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic begin_test();
        exp_q.delete();
        nwords       = 0;
        saw_last     = 1'b0;
        seen_valid   = 1'b0;
        stalled_prev = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic config_trig(input logic [DW-1:0] m, input logic [DW-1:0] v,
                               input logic [DW-1:0] ed, input logic [AW-1:0] p);
        trig_mask  = m;
        trig_value = v;
        trig_edge  = ed;
        pretrig    = p;
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_words"}, 32'(nwords), 32'd16);
        check({tag, "_saw_last"}, 32'(saw_last), 32'd1);
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_triggered"}, 32'(triggered), 32'd1);
        check({tag, "_idle"}, 32'(state), 32'd0);
    endtask

    initial begin
        btnCpuReset = 1'b0;
        probe_in    = '0;
        sample_en   = 1'b1;
        trig_mask   = '0;
        trig_value  = '0;
        trig_edge   = '0;
        pretrig     = '0;
        arm         = 1'b0;
        abort       = 1'b0;
        rd_ready    = 1'b1;
        cnt_mode    = 1'b0;
        slow_mode   = 1'b0;
        edge_mode   = 1'b0;
        rand_ready  = 1'b0;
        ph          = 0;
        k           = 0;
        begin_test();

        // reset state
        repeat (3) tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_last", 32'(rd_last), 32'd0);
        check("rst_trig", 32'(triggered), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        btnCpuReset = 1'b1;
        tick();

        // counter probe, pattern trigger at 0x0040, 4 pre-trigger samples
        begin_test();
        cnt_mode = 1'b1;
        probe_in = '0;
        repeat (16) tick();
        config_trig(16'hFFFF, 16'h0040, 16'h0000, 4'd4);
        for (int v = 16'h3C; v <= 16'h4B; v++) exp_q.push_back(DW'(v));
        pulse_arm();
        wait_done("a_done", 300);
        end_checks("a");

        // edge trigger on bit0 with no pre-trigger window
        cnt_mode = 1'b0;
        probe_in = '0;
        repeat (5) tick();
        begin_test();
        config_trig(16'h0000, 16'h0000, 16'h0001, 4'd0);
        for (int kk = 20; kk < 36; kk++) exp_q.push_back(DW'((kk << 1) | 1));
        k = 0;
        edge_mode = 1'b1;
        pulse_arm();
        wait_done("b_done", 300);
        edge_mode = 1'b0;
        end_checks("b");

        // same capture as the first, consumer ready toggling at random
        begin_test();
        cnt_mode = 1'b1;
        probe_in = '0;
        repeat (16) tick();
        config_trig(16'hFFFF, 16'h0040, 16'h0000, 4'd4);
        for (int v = 16'h3C; v <= 16'h4B; v++) exp_q.push_back(DW'(v));
        rand_ready = 1'b1;
        pulse_arm();
        wait_done("c_done", 600);
        rand_ready = 1'b0;
        rd_ready   = 1'b1;
        end_checks("c");

        // maximum pre-trigger window with sampling every third clock
        begin_test();
        slow_mode = 1'b1;
        probe_in  = '0;
        repeat (48) tick();
        config_trig(16'hFFFF, 16'h0040, 16'h0000, 4'd15);
        for (int v = 16'h31; v <= 16'h40; v++) exp_q.push_back(DW'(v));
        pulse_arm();
        for (int i = 0; i < 600 && !triggered; i++) tick();
        check("d_state_at_trig", 32'(state), 32'd4);
        wait_done("d_done", 200);
        slow_mode = 1'b0;
        sample_en = 1'b1;
        end_checks("d");

        // abort while armed, then arm and abort together
        begin_test();
        cnt_mode = 1'b0;
        probe_in = '0;
        config_trig(16'hFFFF, 16'hDEAD, 16'h0000, 4'd2);
        pulse_arm();
        repeat (6) tick();
        check("e_armed", 32'(state), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("e_abort_idle", 32'(state), 32'd0);
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("e_arm_abort_idle", 32'(state), 32'd0);
        repeat (5) tick();
        check("e_still_idle", 32'(state), 32'd0);
        check("e_done", 32'(done), 32'd0);
        check("e_no_valid", 32'(seen_valid), 32'd0);

        // asynchronous reset in the middle of a stalled readout
        begin_test();
        cnt_mode = 1'b1;
        probe_in = '0;
        repeat (16) tick();
        config_trig(16'hFFFF, 16'h0040, 16'h0000, 4'd4);
        rd_ready = 1'b0;
        pulse_arm();
        for (int i = 0; i < 300 && !rd_valid; i++) tick();
        check("f_in_read", 32'(rd_valid), 32'd1);
        repeat (3) tick();
        #2;
        btnCpuReset = 1'b0;
        #1;
        check("f_rst_state", 32'(state), 32'd0);
        check("f_rst_valid", 32'(rd_valid), 32'd0);
        check("f_rst_done", 32'(done), 32'd0);
        check("f_rst_trig", 32'(triggered), 32'd0);
        stalled_prev = 1'b0;
        tick();
        btnCpuReset = 1'b1;
        rd_ready    = 1'b1;
        tick();
        check("f_after_rst", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/la_capture_core.md
# la_capture_core

Trigger-and-capture engine for the logic analyzer kernel. Samples the 16 probe lines from the JB/JA connectors into a circular sample RAM and holds a programmable pre-trigger window. It detects a pattern/edge trigger and fills the post-trigger window. It then streams the whole capture, oldest sample first, over a valid/ready port to the command/control hub, which forwards it to the UART transmitter.

## Interface
- `DW`, 16, probe/sample width
- `AW`, 10, sample RAM address width; DEPTH = 2^AW samples

- `clk`  in  1  system clock (100 MHz)
- `btnCpuReset`  in  1  asynchronous, active-low reset
- `probe_in`  in  DW  raw probe lines {JB, JA}, asynchronous to clk
- `sample_en`  in  1  sample strobe from the rate divider; tie high for full rate
- `trig_mask`  in  DW  bits participating in the pattern compare
- `trig_value`  in  DW  required value on masked bits
- `trig_edge`  in  DW  bits of which at least one must change; 0 = level-only trigger
- `pretrig`  in  AW  number of samples kept before the trigger sample
- `arm`  in  1  one-cycle start pulse
- `abort`  in  1  one-cycle cancel pulse
- `rd_data`  out  DW  sample being streamed
- `rd_valid`  out  1  rd_data valid
- `rd_last`  out  1  qualifies the final sample (DEPTH-th)
- `rd_ready`  in  1  consumer accepts when rd_valid && rd_ready
- `state`  out  3  current FSM state encoding
- `triggered`  out  1  sticky; set at trigger, cleared on arm
- `done`  out  1  sticky; set after rd_last accepted, cleared on arm

## Operation
- `probe_in` passes through a 2-flop synchronizer to give `s`. `s_prev` is `s` at the previous sample_en.
- Trigger hit = `((s ^ trig_value) & trig_mask) == 0` && (`trig_edge == 0` || `|((s ^ s_prev) & trig_edge)`). Evaluated only on sample_en cycles in ARMED.
- All sample cycles (FILL/ARMED/POST with sample_en) write `s` to RAM at `wr_addr`, then `wr_addr` increments mod DEPTH.
- States: IDLE=0, FILL=1, ARMED=2, POST=3, READ=4.
  - IDLE: on `arm`, clear `wr_addr`, the counters, `triggered` and `done`, and latch `pretrig` and the trigger config. Go to FILL, or to ARMED if pretrig==0.
  - FILL: count written samples; when count reaches pretrig, go to ARMED. The trigger is not evaluated here.
  - ARMED: on a hit, the hit sample is written, `trig_addr <= wr_addr`, `triggered <= 1`, and the post counter loads DEPTH-1-pretrig. Go to POST, or to READ if that count is 0.
  - POST: decrement the counter per sample; at 0, go to READ.
  - READ: `rd_addr` starts at (trig_addr - pretrig) mod DEPTH and streams DEPTH words. After `rd_last` is accepted, set `done` and go to IDLE.
- `abort` in any state goes to IDLE next cycle and drops `rd_valid` and `rd_last`. `done` is not set. `abort` wins over a simultaneous `arm`.
- `arm` outside IDLE is ignored.
- Config inputs are sampled only at arm; later changes have no effect until the next arm.

## Timing
- Reset: state=IDLE; `rd_valid`, `rd_last`, `triggered` and `done` are 0; `rd_data` is 0; `wr_addr` and counters are 0.
- Probe to RAM latency is 2 clk (synchronizer) plus the write cycle. The trigger compares the same `s` that is written that cycle.
- RAM is synchronous read with 1 clk latency. The first `rd_valid` comes 2 clk after entry to READ.
- Handshake:
  - `rd_data` and `rd_last` hold stable while `rd_valid && !rd_ready`.
  - Once asserted, `rd_valid` stays high until transfer or abort.
  - With `rd_ready` held high, throughput is 1 word/clk; a prefetch register is required.
- pretrig = DEPTH-1 is legal; the post window is then the trigger sample only.
- `sample_en` low stalls FILL, ARMED and POST without losing state.
- Address arithmetic wraps mod DEPTH.

## Test plan
Bench uses AW=4 (DEPTH=16).
- Reset mid-READ (`btnCpuReset` low for 1 clk) -> state=0, `rd_valid`=0, `done`=0 and `triggered`=0 immediately (async).
- Counter probe (probe_in = cycle count), `sample_en`=1, pretrig=4, mask=FFFF, value=0x0040, edge=0 -> 16 words 0x003C..0x004B, `rd_last` on 0x004B, `triggered`=1, `done`=1.
- Edge trigger: mask=0, edge=0x0001, probe bit0 rises at the 20th sample, pretrig=0 -> first streamed word is the sample with bit0=1, and 16 words in total.
- `rd_ready` toggled 1/0 at random -> identical 16-word sequence, with no duplicates and no drops, and `rd_data` stable while stalled.
- pretrig=15, `sample_en` every 3rd clk -> READ entered right at trigger; the 16th word is the trigger sample.
- `abort` in ARMED, then `arm` with `abort` in the same cycle -> IDLE both times, `done`=0 and no `rd_valid`.
